// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates the Memory address/data port between the CPU (A) and loader (B); define MEM_ARB_RR_EN for a round-robin base policy, otherwise A has fixed priority
module mem_port_arbiter #(
  parameter int LOCK_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        A_Req,
  input  logic        B_Req,
  input  logic        A_Wr,
  input  logic        B_Wr,
  input  logic [15:0] A_Addr,
  input  logic [15:0] B_Addr,
  input  logic [15:0] A_WData,
  input  logic [15:0] B_WData,
  input  logic        A_Lock,
  input  logic        B_Lock,
  output logic        A_Gnt,
  output logic        B_Gnt,
  output logic        A_Done,
  output logic        B_Done,
  output logic [15:0] RData,
  output logic [15:0] Mem_Addr,
  output logic [15:0] Mem_WData,
  output logic        Mem_Write,
  input  logic [15:0] Mem_RData
);
  localparam int LW = ($clog2(LOCK_MAX + 1) > 3) ? $clog2(LOCK_MAX + 1) : 3;
  localparam logic [LW-1:0] LMAX = LW'(LOCK_MAX);
  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;
  state_t state, state_nx;
  logic own, wr, lock_l;
  logic any_req, arb, own_req, oth_req, lock_win, force_rel, base_win, win;
  logic [15:0] addr, wdata, rdata;
  logic [LW-1:0] lcnt, lcnt_nx;
`ifdef MEM_ARB_RR_EN
  logic rr_last;
  // round-robin pointer holds the last winner; its reset value lets A win the first contention
  always_ff @(posedge CLK) begin
    if (!RST_N) rr_last <= 1'b1;
    else if (arb) rr_last <= win;
  end
  assign base_win = (A_Req && B_Req) ? ~rr_last : B_Req;
`else
  assign base_win = ~A_Req;
`endif
  // winner selection: lock continuation, then forced lock release, then base policy
  always_comb begin
    any_req = A_Req | B_Req;
    arb = any_req && (state != ACCESS);
    own_req = own ? B_Req : A_Req;
    oth_req = own ? A_Req : B_Req;
    lock_win = lock_l && own_req && (lcnt < LMAX);
    force_rel = (lcnt == LMAX) && oth_req;
    win = lock_win ? own : force_rel ? ~own : base_win;
    lcnt_nx = (lock_l && (win == own)) ? ((lcnt == LMAX) ? lcnt : lcnt + 1'b1) : '0;
  end
  // next state and port outputs; the write strobe is gated so reset aborts an access in flight
  always_comb begin
    state_nx = (state == ACCESS) ? COMPLETE : any_req ? ACCESS : IDLE;
    A_Gnt = (state == ACCESS) && !own;
    B_Gnt = (state == ACCESS) && own;
    A_Done = (state == COMPLETE) && !own;
    B_Done = (state == COMPLETE) && own;
    Mem_Write = (state == ACCESS) && wr && RST_N;
    Mem_Addr = addr;
    Mem_WData = wdata;
    RData = rdata;
  end
  // state register
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else state <= state_nx;
  end
  // latch the winning request at arbitration and capture read data at the end of ACCESS
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      own <= 1'b0;
      wr <= 1'b0;
      lock_l <= 1'b0;
      lcnt <= '0;
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
    end else begin
      if (arb) begin
        own <= win;
        wr <= win ? B_Wr : A_Wr;
        lock_l <= win ? B_Lock : A_Lock;
        addr <= win ? B_Addr : A_Addr;
        wdata <= win ? B_WData : A_WData;
        lcnt <= lcnt_nx;
      end
      if (state == ACCESS && !wr) rdata <= Mem_RData;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand sequences for contention, lock limit and reset corners
module tb_mem_port_arbiter;
  logic CLK = 1'b0;
  logic RST_N, A_Req, B_Req, A_Wr, B_Wr, A_Lock, B_Lock;
  logic [15:0] A_Addr, B_Addr, A_WData, B_WData;
  logic A_Gnt, B_Gnt, A_Done, B_Done, Mem_Write;
  logic [15:0] RData, Mem_Addr, Mem_WData, Mem_RData;
  logic [15:0] mem [0:255];
  bit seeded = 1'b0;
  int checks = 0;
  int errors = 0;
  logic found;

  always #5 CLK = ~CLK;

  mem_port_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .A_Req(A_Req), .B_Req(B_Req), .A_Wr(A_Wr), .B_Wr(B_Wr),
    .A_Addr(A_Addr), .B_Addr(B_Addr), .A_WData(A_WData), .B_WData(B_WData),
    .A_Lock(A_Lock), .B_Lock(B_Lock),
    .A_Gnt(A_Gnt), .B_Gnt(B_Gnt), .A_Done(A_Done), .B_Done(B_Done),
    .RData(RData), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .Mem_Write(Mem_Write), .Mem_RData(Mem_RData)
  );

  // Memory model: combinational read, write on the rising edge; seeded with 0x5000+address
  assign Mem_RData = mem[Mem_Addr[7:0]];
  always @(posedge CLK) begin
    if (!seeded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h5000 + 16'(i);
      seeded <= 1'b1;
    end else if (Mem_Write) mem[Mem_Addr[7:0]] <= Mem_WData;
  end

  typedef struct {
    string nm;
    logic rn, ar, aw;
    logic [15:0] aa, ad;
    logic br;
    logic [15:0] ba;
    logic [3:0] ex;
    logic mw;
    logic [15:0] ea, rd;
  } vec_t;
  vec_t tbl [13];

  function automatic vec_t mk(string nm, logic rn, logic ar, logic aw, logic [15:0] aa, logic [15:0] ad,
                              logic br, logic [15:0] ba, logic [3:0] ex, logic mw, logic [15:0] ea, logic [15:0] rd);
    vec_t v;
    v.nm = nm; v.rn = rn; v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
    v.br = br; v.ba = ba; v.ex = ex; v.mw = mw; v.ea = ea; v.rd = rd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc;
    @(negedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0; A_Req = 1'b0; B_Req = 1'b0; A_Wr = 1'b0; B_Wr = 1'b0; A_Lock = 1'b0; B_Lock = 1'b0;
    A_Addr = '0; B_Addr = '0; A_WData = '0; B_WData = '0;
    @(posedge CLK);
    @(negedge CLK);
    // ex = {A_Gnt, B_Gnt, A_Done, B_Done}
    tbl[0]  = mk("rst_a",    0, 1, 0, 16'h0010, 16'h0000, 1, 16'h0020, 4'b0000, 0, 16'h0000, 16'h0000);
    tbl[1]  = mk("rst_b",    0, 1, 0, 16'h0010, 16'h0000, 1, 16'h0020, 4'b0000, 0, 16'h0000, 16'h0000);
    tbl[2]  = mk("release",  1, 1, 0, 16'h0010, 16'h0000, 1, 16'h0020, 4'b0000, 0, 16'h0000, 16'h0000);
    tbl[3]  = mk("a_gnt",    1, 0, 0, 16'h0010, 16'h0000, 1, 16'h0020, 4'b1000, 0, 16'h0010, 16'h0000);
    tbl[4]  = mk("a_done",   1, 0, 0, 16'h0010, 16'h0000, 1, 16'h0020, 4'b0010, 0, 16'h0010, 16'h5010);
    tbl[5]  = mk("b_gnt",    1, 0, 0, 16'h0010, 16'h0000, 0, 16'h0020, 4'b0100, 0, 16'h0020, 16'h5010);
    tbl[6]  = mk("b_done",   1, 0, 0, 16'h0010, 16'h0000, 0, 16'h0020, 4'b0001, 0, 16'h0020, 16'h5020);
    tbl[7]  = mk("wr_req",   1, 1, 1, 16'h0001, 16'hDEAD, 0, 16'h0020, 4'b0000, 0, 16'h0020, 16'h5020);
    tbl[8]  = mk("wr_gnt",   1, 0, 1, 16'h0001, 16'hDEAD, 0, 16'h0020, 4'b1000, 1, 16'h0001, 16'h5020);
    tbl[9]  = mk("wr_done",  1, 1, 0, 16'h0001, 16'h0000, 0, 16'h0020, 4'b0010, 0, 16'h0001, 16'h5020);
    tbl[10] = mk("rd_gnt",   1, 0, 0, 16'h0001, 16'h0000, 0, 16'h0020, 4'b1000, 0, 16'h0001, 16'h5020);
    tbl[11] = mk("rd_done",  1, 0, 0, 16'h0001, 16'h0000, 0, 16'h0020, 4'b0010, 0, 16'h0001, 16'hDEAD);
    tbl[12] = mk("idle",     1, 0, 0, 16'h0001, 16'h0000, 0, 16'h0020, 4'b0000, 0, 16'h0001, 16'hDEAD);
    for (int k = 0; k < 13; k++) begin
      RST_N = tbl[k].rn; A_Req = tbl[k].ar; A_Wr = tbl[k].aw; A_Addr = tbl[k].aa; A_WData = tbl[k].ad;
      B_Req = tbl[k].br; B_Addr = tbl[k].ba;
      #1;
      check($sformatf("%s/gnt_done", tbl[k].nm), {12'h000, A_Gnt, B_Gnt, A_Done, B_Done}, {12'h000, tbl[k].ex});
      check($sformatf("%s/mem_write", tbl[k].nm), Mem_Write, tbl[k].mw);
      check($sformatf("%s/mem_addr", tbl[k].nm), Mem_Addr, tbl[k].ea);
      check($sformatf("%s/rdata", tbl[k].nm), RData, tbl[k].rd);
      @(negedge CLK);
    end
    #1;
    check("mem_written", mem[1], 16'hDEAD);
    check("mem_wdata_held", Mem_WData, 16'h0000);
    RST_N = 1'b0;
    cyc();
    RST_N = 1'b1;
    A_Req = 1'b1; A_Wr = 1'b0; A_Addr = 16'h0030; B_Req = 1'b1; B_Wr = 1'b0; B_Addr = 16'h0040;
`ifdef MEM_ARB_RR_EN
    for (int i = 1; i <= 8; i++) begin
      cyc();
      check("rr_a_gnt", A_Gnt, (i % 4) == 1);
      check("rr_b_gnt", B_Gnt, (i % 4) == 3);
      if (i == 4) check("rr_b_rdata", RData, 16'h5040);
    end
    A_Req = 1'b0; B_Req = 1'b0;
    cyc();
`else
    for (int i = 1; i <= 16; i++) begin
      cyc();
      check("fp_a_gnt", A_Gnt, (i % 2) == 1);
      check("fp_b_gnt", B_Gnt, 1'b0);
      if (i == 2) check("fp_a_rdata", RData, 16'h5030);
    end
    A_Req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2 && !found; i++) begin
      cyc();
      found = B_Gnt;
    end
    check("fp_b_gnt_after_release", found, 1'b1);
    B_Req = 1'b0;
    cyc();
    check("fp_b_done", B_Done, 1'b1);
    check("fp_b_rdata", RData, 16'h5040);
    cyc();
`endif
    B_Req = 1'b1; B_Lock = 1'b1; B_Addr = 16'h0050;
    for (int i = 1; i <= 11; i++) begin
      cyc();
      check("lk_b_gnt", B_Gnt, ((i % 2) == 1) && (i <= 9));
      check("lk_a_gnt", A_Gnt, i == 11);
      if (i == 10) check("lk_lcnt_sat", 16'(dut.lcnt), 16'd4);
      if (i == 1) begin
        A_Req = 1'b1; A_Addr = 16'h0060;
      end
    end
    check("lk_lcnt_clr", 16'(dut.lcnt), 16'd0);
    A_Req = 1'b0; B_Req = 1'b0; B_Lock = 1'b0;
    cyc();
    check("lk_a_done", A_Done, 1'b1);
    check("lk_a_rdata", RData, 16'h5060);
    cyc();
    A_Req = 1'b1; A_Wr = 1'b1; A_Addr = 16'h0005; A_WData = 16'h1111;
    cyc();
    check("rw_mw_pre", Mem_Write, 1'b1);
    RST_N = 1'b0; A_Req = 1'b0;
    #1;
    check("rw_mw_abort", Mem_Write, 1'b0);
    cyc();
    RST_N = 1'b1;
    check("rw_no_done", A_Done, 1'b0);
    check("rw_rdata_rst", RData, 16'h0000);
    cyc();
    check("rw_no_done2", A_Done, 1'b0);
    A_Req = 1'b1; A_Wr = 1'b0; A_Addr = 16'h0005;
    cyc();
    check("rw_rd_gnt", A_Gnt, 1'b1);
    A_Req = 1'b0;
    cyc();
    check("rw_rd_done", A_Done, 1'b1);
    check("rw_prior_value", RData, 16'h5005);
    cyc();
    A_Req = 1'b1; A_Addr = 16'h0006;
    cyc();
    A_Req = 1'b0;
    cyc();
    RST_N = 1'b0;
    #1;
    check("rc_done", A_Done, 1'b1);
    check("rc_rdata", RData, 16'h5006);
    cyc();
    RST_N = 1'b1;
    check("rc_rdata_rst", RData, 16'h0000);
    check("rc_done_rst", A_Done, 1'b0);
    check("rc_addr_rst", Mem_Addr, 16'h0000);
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
